// File: rtl/ram_scan_pkg.sv
// Shared types and helpers for the scanned RAM display path.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_UP   = 2'b00,
    SCAN_DOWN = 2'b01,
    HOLD      = 2'b10,
    MANUAL    = 2'b11
  } scan_mode_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_scan_unit_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick
// TICK_DIV cycles after reset release.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/ram_scan_unit.sv
// Simple dual-port RAM whose read port is driven by a scan address generator
// (up / down / hold / manual step), with write-first read forwarding.
module ram_scan_unit
  import ram_scan_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              tick
);

  localparam int DEPTH = depth_of(ADDR_W);

  scan_mode_t        mode_e;
  logic              adv;
  logic              step_q,    step_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign mode_e = scan_mode_t'(mode);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    adv        = 1'b0;
    step_d     = step;
    rd_addr_d  = rd_addr_q;
    case (mode_e)
      SCAN_UP: begin
        adv = tick;
        if (adv) rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      SCAN_DOWN: begin
        adv = tick;
        if (adv) rd_addr_d = rd_addr_q - ADDR_W'(1);
      end
      MANUAL: begin
        // step_q tracks step in every mode, so entering MANUAL with step high is not an edge.
        adv = step & ~step_q;
        if (adv) rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      default: adv = 1'b0;
    endcase
    rd_valid_d = adv;
    rd_data_d  = (wr_en && (wr_addr == rd_addr_d)) ? wr_data : mem[rd_addr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      step_q     <= step_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the array has no reset; clearing it would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_scan_unit.sv
// Scoreboard bench for ram_scan_unit: stimulus pushes expected words, a
// negedge monitor pops and compares on every rd_valid pulse.
module tb_ram_scan_unit;
  import ram_scan_pkg::*;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 5;
  localparam int TICK_DIV = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        mode;
  logic              step;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              tick;

  int checks   = 0;
  int failures = 0;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic              prev_valid = 1'b0;
  logic [DATA_W-1:0] model_mem [0:31];

  ram_scan_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mode     (mode),
    .step     (step),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has run.
  task automatic step_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int addr);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = model_mem[addr];
    exp_q.push_back(e);
  endtask

  task automatic write_word(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = DATA_W'(data);
    model_mem[addr] = DATA_W'(data);
  endtask

  task automatic wait_drain(input string name, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      step_cyc(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rd_valid) begin
        check("valid_one_cycle", prev_valid, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid_addr", rd_addr, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_rd_addr", rd_addr, mon_e.addr);
          check("sb_rd_data", rd_data, mon_e.data);
        end
      end
      prev_valid = rd_valid;
    end
  end

  initial begin
    int ticks;
    int valids;
    int n;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    mode    = HOLD;
    step    = 1'b0;
    step_cyc(2);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_tick", tick, 0);
    reset = 1'b0;

    // Fill mem[k] = k mod 16 while holding at address 0.
    for (int k = 0; k < 32; k++) begin
      write_word(k, k % 16);
      step_cyc(1);
    end
    wr_en = 1'b0;
    step_cyc(1);
    check("fill_hold_addr", rd_addr, 0);
    check("fill_hold_data", rd_data, 0);

    // Full upward scan 0 -> 31 -> 0.
    for (int k = 1; k <= 32; k++) push_exp(k % 32);
    mode = SCAN_UP;
    wait_drain("drain_scan_up", 200);
    mode = HOLD;

    // Down from 0 wraps to 31.
    push_exp(31);
    mode = SCAN_DOWN;
    wait_drain("drain_scan_down", 20);
    mode = HOLD;
    check("down_wrap_data", rd_data, 4'hF);

    // Up from 31 through the wrap to 7.
    for (int k = 0; k <= 7; k++) push_exp(k);
    mode = SCAN_UP;
    wait_drain("drain_to_7", 60);
    mode = HOLD;

    // HOLD for 20 cycles: divider keeps running, no advance.
    ticks  = 0;
    valids = 0;
    for (int i = 0; i < 20; i++) begin
      step_cyc(1);
      if (tick) ticks++;
      if (rd_valid) valids++;
    end
    check("hold_ticks", ticks, 5);
    check("hold_valids", valids, 0);
    check("hold_addr", rd_addr, 7);

    // Enter MANUAL with step already high: no advance, ticks ignored.
    step = 1'b1;
    step_cyc(2);
    mode = MANUAL;
    step_cyc(10);
    check("manual_entry_addr", rd_addr, 7);
    step = 1'b0;
    step_cyc(2);
    push_exp(8);
    step = 1'b1;
    step_cyc(10);
    check("manual_held_addr", rd_addr, 8);
    check("manual_first_drain", exp_q.size(), 0);
    step = 1'b0;
    step_cyc(2);
    push_exp(9);
    step = 1'b1;
    step_cyc(5);
    step = 1'b0;
    mode = HOLD;
    step_cyc(2);
    check("manual_final_addr", rd_addr, 9);
    check("manual_second_drain", exp_q.size(), 0);

    // Write to the held address forwards without a valid pulse.
    write_word(9, 4'hA);
    step_cyc(1);
    wr_en = 1'b0;
    check("fwd_hold_data", rd_data, 4'hA);
    check("fwd_hold_valid", rd_valid, 0);
    step_cyc(2);
    check("fwd_hold_stored", rd_data, 4'hA);

    // Move to 8, plant a different value in mem[9], then advance onto 9 while writing 0xA.
    push_exp(8);
    mode = SCAN_DOWN;
    wait_drain("drain_to_8", 20);
    mode = HOLD;
    write_word(9, 4'h3);
    step_cyc(1);
    wr_en = 1'b0;
    check("other_addr_write_data", rd_data, 4'h8);
    mode = MANUAL;
    step_cyc(1);
    write_word(9, 4'hA);
    push_exp(9);
    step = 1'b1;
    step_cyc(1);
    wr_en = 1'b0;
    wait_drain("drain_fwd_adv", 5);
    step = 1'b0;
    mode = HOLD;
    step_cyc(1);

    // Scan up to 20, then reset asynchronously mid-cycle.
    for (int k = 10; k <= 20; k++) push_exp(k);
    mode = SCAN_UP;
    wait_drain("drain_to_20", 80);
    check("pre_reset_addr", rd_addr, 20);
    check("pre_reset_data", rd_data, 4);
    #1 reset = 1'b1;
    #1;
    check("async_reset_addr", rd_addr, 0);
    check("async_reset_data", rd_data, 0);
    check("async_reset_valid", rd_valid, 0);
    check("async_reset_tick", tick, 0);
    step_cyc(2);
    push_exp(1);
    reset = 1'b0;
    n = 0;
    while (!rd_valid && n < 20) begin
      step_cyc(1);
      n++;
    end
    check("first_adv_after_reset_cycles", n, 4);
    mode = HOLD;
    step_cyc(2);
    check("post_reset_addr", rd_addr, 1);
    wait_drain("drain_final", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_scan_unit.md
Name: ram_scan_unit

Overview:
Parametrised successor to the board-level 32x4 RAM demo. It is a simple dual-port RAM with a synchronous write port and a read port driven by an internal scan address generator. The scan address can count up or down on a divided tick, hold, or step manually. Read data is forwarded write-first, and a valid pulse marks each new word. It sits between the switch/key input registers and the hex-display decoders.

Parameters:
DATA_W, 4, word width in bits.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
TICK_DIV, 50_000_000, clk cycles per scan tick (>= 2).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  write strobe, level; one word written per cycle while high.
wr_addr  input  ADDR_W  write address.
wr_data  input  DATA_W  write data.
mode  input  2  scan mode: 00 SCAN_UP, 01 SCAN_DOWN, 10 HOLD, 11 MANUAL.
step  input  1  manual advance, level; acts only on a rising edge, only in MANUAL.
rd_addr  output  ADDR_W  current scan address.
rd_data  output  DATA_W  registered contents of mem[rd_addr].
rd_valid  output  1  one-cycle pulse when rd_data reflects a newly advanced rd_addr.
tick  output  1  one-cycle pulse from the divider.

Behaviour:
- Reset (asynchronous, active-high):
  - rd_addr = 0, rd_data = 0, rd_valid = 0, tick = 0.
  - Divider count = 0; step edge register = 0.
  - RAM contents are NOT reset; they are undefined until written.
- Divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly the cycle in which div_cnt == TICK_DIV-1, i.e. one pulse every TICK_DIV cycles.
  - The divider free-runs in every mode.
- Advance condition (adv):
  - SCAN_UP/SCAN_DOWN: adv = tick.
  - MANUAL: adv = step & ~step_q, where step_q is step registered once.
  - HOLD: adv = 0.
- Address update:
  - On adv, rd_addr <= rd_addr + 1 (SCAN_UP, MANUAL) or rd_addr - 1 (SCAN_DOWN).
  - Modulo DEPTH: DEPTH-1 wraps to 0 going up; 0 wraps to DEPTH-1 going down.
- Write: on posedge clk with wr_en = 1, mem[wr_addr] <= wr_data.
- Read, 1-cycle latency:
  - Each cycle rd_data <= mem[rd_addr_next], where rd_addr_next is the value rd_addr takes this edge.
  - So rd_data always matches rd_addr from the same edge.
- Write-first forwarding: if wr_en = 1 and wr_addr == rd_addr_next in the same cycle, rd_data <= wr_data (new data, never stale).
- rd_valid is registered, = 1 in the cycle after any edge where adv = 1, otherwise 0. Writes alone never pulse rd_valid.
- Mode change:
  - Takes effect on the next cycle's adv evaluation.
  - rd_addr is preserved and the divider is not restarted.
  - Entering MANUAL with step already high produces no advance.
- Reset asserted mid-scan: everything returns to reset values immediately.
  - Scan restarts at address 0; the first tick arrives TICK_DIV cycles after reset deasserts.
  - A write in flight during reset may or may not land; the bench must not check it.

Decomposition:
- Package ram_scan_pkg:
  - typedef enum logic [1:0] scan_mode_t {SCAN_UP, SCAN_DOWN, HOLD, MANUAL}.
  - Helper constant DEPTH derivation.
- Sub-module tick_divider (params TICK_DIV; ports clk, reset, tick) holds the divider counter; it is reusable for the board's other timed displays.
- The RAM array is inferred in the top module, not a vendor IP instance.

Test Plan (TICK_DIV=4, DATA_W=4, ADDR_W=5):
1. Reset, write mem[k] = k mod 16 for k = 0..31, mode = SCAN_UP -> tick every 4th cycle; rd_addr 0,1,2,...,31,0; rd_data == rd_addr[3:0] with rd_valid pulsing once per advance.
2. SCAN_DOWN from rd_addr = 0 -> after next tick rd_addr = 31 and rd_data = 0xF; rd_valid = 1 for one cycle.
3. HOLD at rd_addr = 7 for 20 cycles -> rd_addr stays 7; tick still pulses; rd_valid stays 0.
4. MANUAL, step held high for 10 cycles, then low, then high -> exactly one advance per rising edge (7->8->9); ticks ignored.
5. HOLD at rd_addr = 9, wr_en with wr_addr = 9, wr_data = 0xA -> next cycle rd_data = 0xA; rd_valid stays 0. Same write on the cycle rd_addr advances to 9 -> rd_data = 0xA with rd_valid = 1.
6. Assert reset asynchronously mid-cycle at rd_addr = 20 -> outputs go to 0 before the next clk edge. After release, first advance occurs exactly 4 cycles later, to rd_addr = 1.
